// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg -- shared definitions for the systolic-array matrix loader.
//   sa_state_e : loader FSM state encoding
//   SA_D_W, SA_M_DIM, SA_X_R, SA_W_C : default element width and dimensions
//   sa_max()   : constant-foldable integer maximum used for derived widths
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int SA_D_W   = 8;
  localparam int SA_M_DIM = 16;
  localparam int SA_X_R   = 16;
  localparam int SA_W_C   = 16;

  typedef enum logic [1:0] {
    S_LOAD_X = 2'd0,
    S_LOAD_W = 2'd1,
    S_START  = 2'd2,
    S_WAIT   = 2'd3
  } sa_state_e;

  function automatic int sa_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sa_mat_loader.sv
// ---------------------------------------------------------------------------
// sa_mat_loader -- collects X rows then W rows from a valid/ready row stream,
// holds both matrices stable for a downstream array feeder, and pulses
// O_START once both are complete. It then waits for a fresh rising edge on
// I_OVER before accepting the next X load.
//
// Ports
//   I_CLK        : clock, rising edge
//   I_SYNC_RST   : synchronous active-high reset
//   I_VALID      : row beat valid
//   O_READY      : loader accepts a beat (S_LOAD_X / S_LOAD_W)
//   I_IS_W       : beat tag, 0 = X row, 1 = W row
//   I_ROW        : row data, V_W lanes of D_W bits
//   I_OVER       : done level from the downstream feeder
//   O_START      : one-cycle pulse, both matrices complete
//   O_X_MATRIX   : buffered X, X_R x M_DIM
//   O_W_MATRIX   : buffered W, M_DIM x W_C
//   O_ERR        : one-cycle pulse after a tag-mismatched beat is dropped
//   O_BUSY       : high in S_START and S_WAIT
// ---------------------------------------------------------------------------
module sa_mat_loader
  import sa_pkg::*;
#(
  parameter int D_W   = SA_D_W,
  parameter int M_DIM = SA_M_DIM,
  parameter int X_R   = SA_X_R,
  parameter int W_C   = SA_W_C,
  localparam int V_W  = sa_max(M_DIM, W_C)
) (
  input  logic                                  I_CLK,
  input  logic                                  I_SYNC_RST,
  input  logic                                  I_VALID,
  output logic                                  O_READY,
  input  logic                                  I_IS_W,
  input  logic [0:V_W-1][D_W-1:0]               I_ROW,
  input  logic                                  I_OVER,
  output logic                                  O_START,
  output logic [0:X_R-1][0:M_DIM-1][D_W-1:0]    O_X_MATRIX,
  output logic [0:M_DIM-1][0:W_C-1][D_W-1:0]    O_W_MATRIX,
  output logic                                  O_ERR,
  output logic                                  O_BUSY
);

  localparam int RI_W = $clog2(sa_max(X_R, M_DIM) + 1);

  sa_state_e                                state_q, state_d;
  logic [RI_W-1:0]                          row_idx_q, row_idx_d;
  logic                                     over_q, over_d;
  logic [0:X_R-1][0:M_DIM-1][D_W-1:0]       x_q, x_d;
  logic [0:M_DIM-1][0:W_C-1][D_W-1:0]       w_q, w_d;
  logic                                     start_q, start_d;
  logic                                     err_q, err_d;
  logic                                     ready_q, ready_d;
  logic                                     busy_q, busy_d;

  logic                                     accept_s;
  logic                                     wr_x_s;
  logic                                     wr_w_s;
  logic                                     over_rise_s;

  // Next state, row counter, matrix writes and tag-error decode.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    x_d         = x_q;
    w_d         = w_q;
    over_d      = I_OVER;
    // ready_q mirrors the registered state, so no path from I_VALID reaches O_READY.
    accept_s    = I_VALID && ready_q;
    wr_x_s      = accept_s && (state_q == S_LOAD_X) && !I_IS_W;
    wr_w_s      = accept_s && (state_q == S_LOAD_W) && I_IS_W;
    err_d       = accept_s && (((state_q == S_LOAD_X) && I_IS_W) ||
                               ((state_q == S_LOAD_W) && !I_IS_W));
    // Only a fresh 0->1 on I_OVER ends the wait; a level left over from the
    // previous run is ignored.
    over_rise_s = I_OVER && !over_q;

    for (int r = 0; r < X_R; r++) begin
      if (wr_x_s && (row_idx_q == RI_W'(r))) begin
        x_d[r] = I_ROW[0:M_DIM-1];
      end else begin
        x_d[r] = x_q[r];
      end
    end

    for (int r = 0; r < M_DIM; r++) begin
      if (wr_w_s && (row_idx_q == RI_W'(r))) begin
        w_d[r] = I_ROW[0:W_C-1];
      end else begin
        w_d[r] = w_q[r];
      end
    end

    case (state_q)
      S_LOAD_X: begin
        if (wr_x_s && (row_idx_q == RI_W'(X_R - 1))) begin
          state_d = S_LOAD_W;
        end else begin
          state_d = S_LOAD_X;
        end
      end
      S_LOAD_W: begin
        if (wr_w_s && (row_idx_q == RI_W'(M_DIM - 1))) begin
          state_d = S_START;
        end else begin
          state_d = S_LOAD_W;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (over_rise_s) begin
          state_d = S_LOAD_X;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_LOAD_X;
      end
    endcase

    // Counter restarts on every state change; mismatched beats leave it alone.
    if (state_d != state_q) begin
      row_idx_d = '0;
    end else if (wr_x_s || wr_w_s) begin
      row_idx_d = row_idx_q + RI_W'(1);
    end else begin
      row_idx_d = row_idx_q;
    end
  end

  // Output decode from the upcoming state so the outputs leave a flop.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    start_d = 1'b0;
    case (state_d)
      S_LOAD_X, S_LOAD_W: begin
        ready_d = 1'b1;
      end
      S_START: begin
        busy_d  = 1'b1;
        start_d = 1'b1;
      end
      S_WAIT: begin
        busy_d  = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // State register and all datapath flops; reset wins over any beat.
  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      state_q   <= S_LOAD_X;
      row_idx_q <= '0;
      over_q    <= 1'b0;
      x_q       <= '0;
      w_q       <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      over_q    <= over_d;
      x_q       <= x_d;
      w_q       <= w_d;
      start_q   <= start_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign O_READY    = ready_q;
  assign O_START    = start_q;
  assign O_ERR      = err_q;
  assign O_BUSY     = busy_q;
  assign O_X_MATRIX = x_q;
  assign O_W_MATRIX = w_q;

endmodule

// File: tb/tb_sa_mat_loader.sv
// ---------------------------------------------------------------------------
// tb_sa_mat_loader -- directed bench for sa_mat_loader with 4x4 matrices of
// 8-bit elements. Inputs change 1 time unit after the rising edge and outputs
// are checked at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_sa_mat_loader;

  typedef logic [0:3][7:0]       row_t;
  typedef logic [0:3][0:3][7:0]  mat_t;

  logic I_CLK = 1'b0;
  logic I_SYNC_RST;
  logic I_VALID;
  logic O_READY;
  logic I_IS_W;
  row_t I_ROW;
  logic I_OVER;
  logic O_START;
  mat_t O_X_MATRIX;
  mat_t O_W_MATRIX;
  logic O_ERR;
  logic O_BUSY;

  mat_t exp_x;
  mat_t exp_w;
  int   n_cmp = 0;
  int   n_err = 0;

  sa_mat_loader #(
    .D_W   (8),
    .M_DIM (4),
    .X_R   (4),
    .W_C   (4)
  ) dut (
    .I_CLK      (I_CLK),
    .I_SYNC_RST (I_SYNC_RST),
    .I_VALID    (I_VALID),
    .O_READY    (O_READY),
    .I_IS_W     (I_IS_W),
    .I_ROW      (I_ROW),
    .I_OVER     (I_OVER),
    .O_START    (O_START),
    .O_X_MATRIX (O_X_MATRIX),
    .O_W_MATRIX (O_W_MATRIX),
    .O_ERR      (O_ERR),
    .O_BUSY     (O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  function automatic row_t mk_row(input int base);
    row_t r;
    for (int c = 0; c < 4; c++) r[c] = 8'(base + c);
    return r;
  endfunction

  function automatic row_t fill_row(input logic [7:0] v);
    row_t r;
    for (int c = 0; c < 4; c++) r[c] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic send(input logic is_w, input row_t d);
    I_VALID = 1'b1;
    I_IS_W  = is_w;
    I_ROW   = d;
    step();
  endtask

  task automatic idle();
    I_VALID = 1'b0;
    I_IS_W  = 1'b0;
    I_ROW   = fill_row(8'hEE);
    step();
  endtask

  // X rows {r*4+c}, then W rows {16+r*4+c}, valid held high throughout.
  task automatic load_run1();
    for (int r = 0; r < 4; r++) begin
      send(1'b0, mk_row(r * 4));
      exp_x[r] = mk_row(r * 4);
    end
    for (int r = 0; r < 4; r++) begin
      send(1'b1, mk_row(16 + r * 4));
      exp_w[r] = mk_row(16 + r * 4);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_x = '0;
    exp_w = '0;

    // Reset with a beat presented at the same time: nothing may be written.
    I_SYNC_RST = 1'b1;
    I_VALID    = 1'b1;
    I_IS_W     = 1'b0;
    I_ROW      = fill_row(8'hAA);
    I_OVER     = 1'b0;
    step();
    step();
    chk("rst_x_zero", O_X_MATRIX, 128'd0);
    chk("rst_w_zero", O_W_MATRIX, 128'd0);
    chk("rst_start", 128'(O_START), 128'd0);
    chk("rst_err", 128'(O_ERR), 128'd0);
    chk("rst_busy", 128'(O_BUSY), 128'd0);
    I_SYNC_RST = 1'b0;
    idle();
    chk("ready_after_rst", 128'(O_READY), 128'd1);
    chk("x_zero_after_rst", O_X_MATRIX, 128'd0);

    // Full load with a stale I_OVER high from before the run.
    I_OVER = 1'b1;
    load_run1();
    chk("run1_start", 128'(O_START), 128'd1);
    chk("run1_ready", 128'(O_READY), 128'd0);
    chk("run1_busy", 128'(O_BUSY), 128'd1);
    chk("run1_x", O_X_MATRIX, exp_x);
    chk("run1_w", O_W_MATRIX, exp_w);
    chk("run1_x_2_3", 128'(O_X_MATRIX[2][3]), 128'd11);
    chk("run1_w_3_0", 128'(O_W_MATRIX[3][0]), 128'd28);
    I_ROW = fill_row(8'h55);
    step();
    chk("run1_start_once", 128'(O_START), 128'd0);
    chk("run1_hold_x", O_X_MATRIX, exp_x);
    chk("run1_wait_busy", 128'(O_BUSY), 128'd1);
    I_VALID = 1'b0;
    repeat (3) step();
    chk("stale_over_wait", 128'(O_READY), 128'd0);
    I_OVER = 1'b0;
    step();
    chk("over_low_wait", 128'(O_READY), 128'd0);
    I_OVER = 1'b1;
    step();
    chk("over_rise_ready", 128'(O_READY), 128'd1);
    chk("over_rise_busy", 128'(O_BUSY), 128'd0);
    I_OVER = 1'b0;

    // Reset in S_LOAD_X, then a mismatched tag beat.
    I_SYNC_RST = 1'b1;
    I_VALID    = 1'b0;
    step();
    I_SYNC_RST = 1'b0;
    exp_x = '0;
    exp_w = '0;
    chk("rst2_x_zero", O_X_MATRIX, 128'd0);
    send(1'b1, fill_row(8'hFF));
    chk("tag_err_pulse", 128'(O_ERR), 128'd1);
    chk("tag_err_nowrite", O_X_MATRIX, 128'd0);
    idle();
    chk("tag_err_once", 128'(O_ERR), 128'd0);

    // Backpressure: valid alternates, garbage data on idle cycles.
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        send(1'b0, fill_row(8'hFF));
        chk("w_tag_err_pulse", 128'(O_ERR), 128'd1);
        chk("w_tag_err_nowrite", O_W_MATRIX, 128'd0);
        idle();
      end
      if (k < 4) begin
        send(1'b0, mk_row(k * 4));
        exp_x[k] = mk_row(k * 4);
      end else begin
        send(1'b1, mk_row(16 + (k - 4) * 4));
        exp_w[k - 4] = mk_row(16 + (k - 4) * 4);
      end
      if (k == 0) chk("bp_row0_after_err", O_X_MATRIX, exp_x);
      if (k < 7) idle();
      if (k == 1) chk("bp_ready_idle", 128'(O_READY), 128'd1);
    end
    chk("bp_start", 128'(O_START), 128'd1);
    chk("bp_x", O_X_MATRIX, exp_x);
    chk("bp_w", O_W_MATRIX, exp_w);

    // Reset while in S_WAIT.
    idle();
    I_SYNC_RST = 1'b1;
    step();
    I_SYNC_RST = 1'b0;
    exp_x = '0;
    exp_w = '0;
    chk("rst_wait_x", O_X_MATRIX, 128'd0);
    chk("rst_wait_w", O_W_MATRIX, 128'd0);
    chk("rst_wait_ready", 128'(O_READY), 128'd1);
    chk("rst_wait_busy", 128'(O_BUSY), 128'd0);

    // Reset after two W beats, with the third W beat presented alongside.
    for (int r = 0; r < 4; r++) begin
      send(1'b0, mk_row(r * 4));
      exp_x[r] = mk_row(r * 4);
    end
    for (int r = 0; r < 2; r++) begin
      send(1'b1, mk_row(16 + r * 4));
      exp_w[r] = mk_row(16 + r * 4);
    end
    chk("midw_partial_w", O_W_MATRIX, exp_w);
    I_ROW      = mk_row(24);
    I_SYNC_RST = 1'b1;
    step();
    I_SYNC_RST = 1'b0;
    I_VALID    = 1'b0;
    exp_x = '0;
    exp_w = '0;
    chk("midw_rst_x", O_X_MATRIX, 128'd0);
    chk("midw_rst_w", O_W_MATRIX, 128'd0);
    chk("midw_rst_ready", 128'(O_READY), 128'd1);
    for (int i = 0; i < 4; i++) begin
      chk("midw_no_start", 128'(O_START), 128'd0);
      step();
    end

    // Back-to-back runs: second X load overwrites rows in place.
    load_run1();
    idle();
    I_OVER = 1'b1;
    step();
    I_OVER = 1'b0;
    chk("b2b_ready", 128'(O_READY), 128'd1);
    send(1'b0, fill_row(8'd9));
    exp_x[0] = fill_row(8'd9);
    chk("b2b_row0", O_X_MATRIX, exp_x);
    chk("b2b_w_keep", O_W_MATRIX, exp_w);
    send(1'b0, mk_row(100));
    exp_x[1] = mk_row(100);
    chk("b2b_row1", O_X_MATRIX, exp_x);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sa_mat_loader.md
SA_MAT_LOADER -- requirements
Module: sa_mat_loader

Interface
REQ-001 Parameter D_W, 8, element width in bits.
REQ-002 Parameter M_DIM, 16, shared (inner) dimension; the X column count and the W row count.
REQ-003 Parameter X_R, 16, X row count.
REQ-004 Parameter W_C, 16, W column count.
REQ-005 Localparam V_W = max(M_DIM, W_C), lane count of the input row vector.
REQ-006 I_CLK  in  1  sole clock, rising edge.
REQ-007 I_SYNC_RST  in  1  reset, synchronous and active-high.
REQ-008 I_VALID  in  1  input row beat valid.
REQ-009 O_READY  out  1  loader can accept a row beat.
REQ-010 I_IS_W  in  1  beat tag: 0 = X row, 1 = W row.
REQ-011 I_ROW  in  D_W x [0:V_W-1]  row data; X beats use lanes 0..M_DIM-1, W beats use lanes 0..W_C-1.
REQ-012 I_OVER  in  1  done level from the downstream array feeder.
REQ-013 O_START  out  1  one-cycle pulse: both matrices are complete.
REQ-014 O_X_MATRIX  out  D_W x [0:X_R-1][0:M_DIM-1]  buffered X.
REQ-015 O_W_MATRIX  out  D_W x [0:M_DIM-1][0:W_C-1]  buffered W.
REQ-016 O_ERR  out  1  one-cycle pulse when a tag-mismatched beat is discarded.
REQ-017 O_BUSY  out  1  high in S_START and S_WAIT.

Function
REQ-018 FSM states: S_LOAD_X, S_LOAD_W, S_START, S_WAIT.
REQ-019 Handshake: a beat transfers on a rising edge where I_VALID=1 and O_READY=1.
REQ-020 O_READY is decoded from registered state only: 1 in S_LOAD_X and S_LOAD_W, 0 otherwise; it has no combinational path from I_VALID.
REQ-021 Row counter row_idx, width clog2(max(X_R, M_DIM)+1), is cleared on every state change.
REQ-022 In S_LOAD_X, an accepted beat with I_IS_W=0 writes I_ROW[0:M_DIM-1] into O_X_MATRIX[row_idx], and row_idx then increments.
REQ-023 In S_LOAD_W, an accepted beat with I_IS_W=1 writes I_ROW[0:W_C-1] into O_W_MATRIX[row_idx], and row_idx then increments.
REQ-024 Mismatched tag (I_IS_W=1 in S_LOAD_X, or 0 in S_LOAD_W): the beat is consumed and discarded, nothing is written, row_idx holds, and O_ERR=1 in the next cycle only.
REQ-025 Accepting X row X_R-1 moves the FSM to S_LOAD_W; accepting W row M_DIM-1 moves it to S_START.
REQ-026 S_START lasts exactly one cycle with O_START=1, then moves to S_WAIT.
REQ-027 A one-cycle-delayed copy over_q of I_OVER is kept; S_WAIT exits to S_LOAD_X on I_OVER=1 and over_q=0 (rising edge).
REQ-028 A stale high I_OVER, held from the previous run, does not end S_WAIT.
REQ-029 Matrices are written only by accepted, matching beats; they hold in every other state, so both are stable from O_START until S_WAIT exits.
REQ-030 The new X load overwrites rows in place; rows not yet rewritten keep their old data.
REQ-031 Write latency: an accepted beat at edge t is visible on the matrix outputs after edge t.
REQ-032 From the last W beat at edge t, O_START is high during the cycle after edge t.

Reset
REQ-033 While I_SYNC_RST=1 at an edge: state=S_LOAD_X, row_idx=0, over_q=0, all matrix elements=0, O_START=0, O_ERR=0.
REQ-034 Reset has priority over all other events.
REQ-035 A beat presented in the same cycle as reset is not written.
REQ-036 Reset mid-load or during S_WAIT returns the block to S_LOAD_X with all matrices zeroed.
REQ-037 O_READY=1 in the first cycle after reset is released.

Structure
REQ-038 Shared package sa_pkg holds the loader state enum typedef and the default D_W/M_DIM/X_R/W_C constants.
REQ-039 The block is a single module with no sub-module; the rising-edge detect is inline.

Verification (bench parameters: D_W=8, M_DIM=X_R=W_C=4)
REQ-040 Full load: 4 X beats with rows {r*4+c}, then 4 W beats {16+r*4+c}, I_VALID held high -> O_X_MATRIX[2][3]=11, O_W_MATRIX[3][0]=28, O_START high exactly one cycle after the 8th accept, O_READY=0.
REQ-041 Backpressure: I_VALID toggling 1/0 each cycle -> only valid cycles advance row_idx; final matrices are identical to REQ-040.
REQ-042 Tag error: in S_LOAD_X, a beat with I_IS_W=1 and data 0xFF -> O_ERR pulses once, row 0 stays 0, and the next X beat lands in row 0.
REQ-043 Stale done: I_OVER held at 1 through O_START -> the FSM stays in S_WAIT; I_OVER 0 then 1 -> O_READY rises one cycle after the rising edge.
REQ-044 Reset mid-W-load after 2 W beats -> all matrices become 0, state is S_LOAD_X, and O_START never fires.
REQ-045 Back-to-back runs: second load with X row 0 = {9,9,9,9} -> X row 0 updated, rows 1-3 keep run-1 values until rewritten.
